// File: rtl/ej32_obuf_tx.sv
// Console-output responder on the core's byte bus: a 4-byte register window
// whose TXD writes feed a FIFO drained as 8N1 serial frames on tx_o.
module ej32_obuf_tx #(
  parameter int unsigned OBUF         = 'h1400,
  parameter int unsigned ASZ          = 17,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [ASZ-1:0] addr_i,
  input  logic [7:0]     data_i,
  input  logic           dwe_i,
  output logic [7:0]     data_o,
  output logic           hit_o,
  output logic           tx_o,
  output logic           busy_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam logic [ASZ:0] BASE = (ASZ+1)'(OBUF);
  localparam logic [ASZ:0] LAST = BASE + (ASZ+1)'(3);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_d;
  logic [PW-1:0]   wptr, rptr, wptr_d, rptr_d, count;
  logic [7:0]      mem [DEPTH];
  logic            empty, empty_d, full, ovf;
  logic            push_req, push, pop, stat_rd, tx_busy;
  logic [ASZ:0]    addr_x;
  logic [1:0]      off;
  logic [7:0]      rdata;
  logic [BW-1:0]   baud, baud_d;
  logic [2:0]      bitc, bit_d;
  logic [7:0]      shreg, shreg_d;
  logic            baud_end, tx_d, busy_d;

  // Window decode is purely combinational; the extra address bit keeps OBUF+3 from wrapping.
  assign addr_x = {1'b0, addr_i};
  assign hit_o  = (addr_x >= BASE) && (addr_x <= LAST);
  assign off    = 2'(addr_i - ASZ'(OBUF));

  assign push_req = hit_o & dwe_i & (off == 2'd0);
  assign stat_rd  = hit_o & ~dwe_i & (off == 2'd1);

  assign count   = wptr - rptr;
  assign empty   = (wptr == rptr);
  assign full    = (count == PW'(DEPTH));
  assign tx_busy = (state != IDLE);
  assign pop     = (state == IDLE) & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push    = push_req & (~full | pop);
  assign wptr_d  = wptr + PW'(push);
  assign rptr_d  = rptr + PW'(pop);
  assign empty_d = (wptr_d == rptr_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      ovf  <= 1'b0;
    end else begin
      wptr <= wptr_d;
      rptr <= rptr_d;
      if (push_req & full & ~pop) ovf <= 1'b1;
      else if (stat_rd)           ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= data_i;
  end

  // Read mux sampled with the address, giving SRAM-like single-cycle latency.
  always_comb begin
    rdata = 8'h00;
    if (hit_o & ~dwe_i) begin
      case (off)
        2'd1:    rdata = {4'b0000, tx_busy, ovf, full, empty};
        2'd2:    rdata = 8'(count);
        default: rdata = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) data_o <= 8'h00;
    else     data_o <= rdata;
  end

  assign baud_end = (baud == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:  if (!empty) state_d = START;
      START: if (baud_end) state_d = DATA;
      DATA:  if (baud_end && (bitc == 3'd7)) state_d = STOP;
      STOP:  if (baud_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // tx_o and busy_o are registered from next-cycle values so they line up with state.
  always_comb begin
    baud_d  = '0;
    bit_d   = bitc;
    shreg_d = shreg;
    case (state)
      IDLE: begin
        if (pop) begin
          shreg_d = mem[rptr[AW-1:0]];
          bit_d   = 3'd0;
        end
      end
      default: begin
        baud_d = baud_end ? '0 : baud + BW'(1);
        if ((state == DATA) && baud_end) begin
          bit_d   = bitc + 3'd1;
          shreg_d = {1'b0, shreg[7:1]};
        end
      end
    endcase
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE) | ~empty_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      baud   <= '0;
      bitc   <= 3'd0;
      shreg  <= 8'h00;
      tx_o   <= 1'b1;
      busy_o <= 1'b0;
    end else begin
      baud   <= baud_d;
      bitc   <= bit_d;
      shreg  <= shreg_d;
      tx_o   <= tx_d;
      busy_o <= busy_d;
    end
  end

endmodule

// File: tb/tb_ej32_obuf_tx.sv
// Directed bench for ej32_obuf_tx: bus-side register checks plus a serial
// monitor that decodes tx_o frames against a queue of expected bytes.
module tb_ej32_obuf_tx;

  localparam int unsigned ASZ   = 17;
  localparam int unsigned OBUF  = 'h1400;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CPB   = 4;

  localparam logic [ASZ-1:0] A_TXD  = ASZ'(OBUF);
  localparam logic [ASZ-1:0] A_STAT = ASZ'(OBUF + 1);
  localparam logic [ASZ-1:0] A_CNT  = ASZ'(OBUF + 2);
  localparam logic [ASZ-1:0] A_RSV  = ASZ'(OBUF + 3);

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [ASZ-1:0] addr_i = '0;
  logic [7:0]     data_i = 8'h00;
  logic           dwe_i = 1'b0;
  logic [7:0]     data_o;
  logic           hit_o, tx_o, busy_o;

  int n_asserts = 0;
  int n_fail    = 0;
  int n_frames  = 0;
  logic [7:0] exp_q [$];

  ej32_obuf_tx #(
    .OBUF(OBUF), .ASZ(ASZ), .DEPTH(DEPTH), .CLKS_PER_BIT(CPB)
  ) dut (
    .clk(clk), .rst(rst), .addr_i(addr_i), .data_i(data_i), .dwe_i(dwe_i),
    .data_o(data_o), .hit_o(hit_o), .tx_o(tx_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [ASZ-1:0] a, input logic [7:0] d);
    addr_i = a;
    data_i = d;
    dwe_i  = 1'b1;
    tick();
    dwe_i  = 1'b0;
    addr_i = '0;
    data_i = 8'h00;
  endtask

  task automatic bus_read(input logic [ASZ-1:0] a, output logic [7:0] d);
    addr_i = a;
    dwe_i  = 1'b0;
    tick();
    d      = data_o;
    addr_i = '0;
  endtask

  task automatic wait_drain(input int budget);
    int i;
    for (i = 0; i < budget && !(busy_o === 1'b0 && exp_q.size() == 0); i++) tick();
    chk("drain_timeout", 32'(i < budget), 32'd1);
  endtask

  // Serial monitor: samples mid-bit on the falling edge; frames hit by reset are discarded.
  logic mon_prev = 1'b1;
  always begin : mon
    logic [7:0] got;
    logic       st, sp, ab;
    @(negedge clk);
    if (mon_prev === 1'b1 && tx_o === 1'b0 && rst === 1'b0) begin
      got = 8'h00; st = 1'bx; sp = 1'bx; ab = 1'b0;
      for (int k = 1; k <= 38; k++) begin
        @(negedge clk);
        if (rst !== 1'b0) ab = 1'b1;
        if (k == 2) st = tx_o;
        if (k >= 6 && k <= 34 && ((k - 6) % 4) == 0) got[(k - 6) / 4] = tx_o;
        if (k == 38) sp = tx_o;
      end
      if (!ab) begin
        n_frames++;
        chk("frame_start_bit", 32'(st), 32'd0);
        chk("frame_stop_bit", 32'(sp), 32'd1);
        chk("frame_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("frame_byte", 32'(got), 32'(exp_q.pop_front()));
      end
    end
    mon_prev = tx_o;
  end

  initial begin : stim
    logic [7:0] rd;
    logic [7:0] b;
    logic       eb;
    int         frames_before;

    // Reset idle
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_tx", 32'(tx_o), 32'd1);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_data", 32'(data_o), 32'd0);
    bus_read(A_STAT, rd);
    chk("rst_stat", 32'(rd), 32'h01);
    bus_read(A_CNT, rd);
    chk("rst_cnt", 32'(rd), 32'h00);

    // Single frame, cycle-exact
    b = 8'hA5;
    exp_q.push_back(b);
    bus_write(A_TXD, b);
    chk("sf_busy_n1", 32'(busy_o), 32'd1);
    chk("sf_tx_n1", 32'(tx_o), 32'd1);
    for (int k = 0; k < 40; k++) begin
      tick();
      eb = (k < 4) ? 1'b0 : (k < 36) ? b[(k - 4) / 4] : 1'b1;
      chk("sf_tx_bit", 32'(tx_o), 32'(eb));
    end
    chk("sf_busy_n41", 32'(busy_o), 32'd1);
    tick();
    chk("sf_busy_n42", 32'(busy_o), 32'd0);
    chk("sf_tx_n42", 32'(tx_o), 32'd1);
    repeat (3) tick();

    // Overflow: six back-to-back writes, the sixth is dropped
    for (int i = 0; i < 6; i++) begin
      if (i < 5) exp_q.push_back(8'(8'h10 + i));
      bus_write(A_TXD, 8'(8'h10 + i));
    end
    bus_read(A_STAT, rd);
    chk("ovf_stat1", 32'(rd), 32'h0E);
    bus_read(A_STAT, rd);
    chk("ovf_stat2", 32'(rd), 32'h0A);
    bus_read(A_CNT, rd);
    chk("ovf_cnt", 32'(rd), 32'd4);
    wait_drain(400);
    chk("ovf_frames", 32'(n_frames), 32'd6);
    repeat (3) tick();

    // Full FIFO with a push landing on the IDLE pop cycle
    exp_q.push_back(8'h3C);
    bus_write(A_TXD, 8'h3C);
    exp_q.push_back(8'hC3); bus_write(A_TXD, 8'hC3);
    exp_q.push_back(8'h5A); bus_write(A_TXD, 8'h5A);
    exp_q.push_back(8'h96); bus_write(A_TXD, 8'h96);
    exp_q.push_back(8'h01); bus_write(A_TXD, 8'h01);
    repeat (37) tick();
    exp_q.push_back(8'hFE);
    bus_write(A_TXD, 8'hFE);
    bus_read(A_CNT, rd);
    chk("fp_cnt", 32'(rd), 32'd4);
    bus_read(A_STAT, rd);
    chk("fp_stat", 32'(rd), 32'h0A);
    wait_drain(400);
    chk("fp_frames", 32'(n_frames), 32'd12);
    repeat (3) tick();

    // Window decode
    addr_i = ASZ'(OBUF - 1); #1;
    chk("win_hit_below", 32'(hit_o), 32'd0);
    addr_i = ASZ'(OBUF + 4); #1;
    chk("win_hit_above", 32'(hit_o), 32'd0);
    addr_i = A_TXD; #1;
    chk("win_hit_base", 32'(hit_o), 32'd1);
    addr_i = A_RSV; #1;
    chk("win_hit_top", 32'(hit_o), 32'd1);
    addr_i = '0;
    bus_read(A_STAT, rd);
    chk("win_stat", 32'(rd), 32'h01);
    bus_write(A_STAT, 8'h77);
    chk("win_data_after_write", 32'(data_o), 32'd0);
    bus_write(A_CNT, 8'h33);
    bus_write(A_RSV, 8'h55);
    bus_read(A_CNT, rd);
    chk("win_cnt", 32'(rd), 32'd0);
    bus_read(A_RSV, rd);
    chk("win_rsv", 32'(rd), 32'd0);
    bus_read(A_TXD, rd);
    chk("win_txd_read", 32'(rd), 32'd0);
    chk("win_busy", 32'(busy_o), 32'd0);

    // Reset mid-frame: abort the frame and flush two queued bytes
    frames_before = n_frames;
    bus_write(A_TXD, 8'h00);
    bus_write(A_TXD, 8'h81);
    bus_write(A_TXD, 8'h42);
    bus_read(A_CNT, rd);
    chk("rmf_cnt_pre", 32'(rd), 32'd2);
    repeat (6) tick();
    chk("rmf_tx_data", 32'(tx_o), 32'd0);
    rst = 1'b1;
    tick();
    chk("rmf_tx_after_rst", 32'(tx_o), 32'd1);
    rst = 1'b0;
    chk("rmf_busy", 32'(busy_o), 32'd0);
    bus_read(A_CNT, rd);
    chk("rmf_cnt_post", 32'(rd), 32'd0);
    repeat (100) tick();
    chk("rmf_no_frames", 32'(n_frames), 32'(frames_before));
    chk("rmf_tx_idle", 32'(tx_o), 32'd1);
    chk("rmf_busy_idle", 32'(busy_o), 32'd0);
    chk("end_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
